// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: state encodings common to tx and rx, and the bit-period derivation.
package uart_tx_pkg;

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  function automatic int unsigned counts_per_bit(input int unsigned base_freq,
                                                 input int unsigned baudrate);
    return base_freq / baudrate;
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period counter: bit_tick is high in the last cycle of every COUNTS_PER_BIT-cycle period.
// The count restarts from zero while clear is high, so each period is aligned to the frame start.
module uart_baud_gen #(
  parameter int unsigned COUNTS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam logic [31:0] LAST = 32'(COUNTS_PER_BIT - 1);

  logic [31:0] clock_ctr_q, clock_ctr_d;

  assign bit_tick = (clock_ctr_q == LAST);

  always_comb begin
    clock_ctr_d = clock_ctr_q + 32'd1;
    if (clear || bit_tick) begin
      clock_ctr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clock_ctr_q <= '0;
    end else begin
      clock_ctr_q <= clock_ctr_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, D0..D7 LSB first, optional even parity, stop; one byte per accepted request.
// Build option UART_TX_PARITY_EN inserts the even-parity bit between D7 and stop (8E1 instead of 8N1).
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned BASE_FREQ = 50_000_000,
  parameter int unsigned BAUDRATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       tx_start,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CPB = counts_per_bit(BASE_FREQ, BAUDRATE);

  logic [2:0] state_q, state_d;
  logic [2:0] d_idx_q, d_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       serial_out_q, serial_out_d;
  logic       tx_busy_q, tx_busy_d;
  logic       tx_done_q, tx_done_d;
  logic       bit_tick;
`ifdef UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  uart_baud_gen #(
    .COUNTS_PER_BIT(CPB)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == TX_IDLE),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    d_idx_d   = d_idx_q;
    shift_d   = shift_q;
    tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      TX_IDLE: begin
        if (tx_start) begin
          shift_d = data_in;
`ifdef UART_TX_PARITY_EN
          parity_d = ^data_in;
`endif
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (bit_tick) begin
          d_idx_d = 3'd0;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_tick) begin
          d_idx_d = d_idx_q + 3'd1;
          if (d_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_tick) begin
          state_d = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (bit_tick) begin
          state_d   = TX_IDLE;
          tx_done_d = 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Line level is derived from the next state so the registered output lines up with it.
    case (state_d)
      TX_START:  serial_out_d = 1'b0;
      TX_DATA:   serial_out_d = shift_d[d_idx_d];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: serial_out_d = parity_d;
`endif
      default:   serial_out_d = 1'b1;
    endcase
    tx_busy_d = (state_d != TX_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= TX_IDLE;
      d_idx_q      <= 3'd0;
      shift_q      <= 8'd0;
      serial_out_q <= 1'b1;
      tx_busy_q    <= 1'b0;
      tx_done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      d_idx_q      <= d_idx_d;
      shift_q      <= shift_d;
      serial_out_q <= serial_out_d;
      tx_busy_q    <= tx_busy_d;
      tx_done_q    <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign serial_out = serial_out_q;
  assign tx_busy    = tx_busy_q;
  assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with N=16 cycles per bit; checks every cycle against a frame-timeline model.
module tb_uart_tx;

  localparam int N = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB      = 11;
  localparam int DONE_AT = 177;
  localparam logic [10:0] BITS_55 = 11'h4AA;
  localparam logic [10:0] BITS_07 = 11'h60E;
  localparam logic [10:0] BITS_3C = 11'h478;
  localparam logic [10:0] BITS_81 = 11'h502;
`else
  localparam int NB      = 10;
  localparam int DONE_AT = 161;
  localparam logic [10:0] BITS_55 = 11'h2AA;
  localparam logic [10:0] BITS_07 = 11'h20E;
  localparam logic [10:0] BITS_3C = 11'h278;
  localparam logic [10:0] BITS_81 = 11'h302;
`endif
  localparam int FL = NB * N;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       tx_start = 1'b0;
  logic       serial_out, tx_busy, tx_done;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  uart_tx #(.BASE_FREQ(16), .BAUDRATE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .tx_start  (tx_start),
    .serial_out(serial_out),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a list of NB line levels, each held N cycles; mpos is the cycle index within it.
  int   mpos = 0;
  bit   mdone = 1'b0;
  logic mframe [0:10];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mpos  = 0;
      mdone = 1'b0;
    end else begin
      mdone = 1'b0;
      if (mpos == 0) begin
        if (tx_start) begin
          mframe[0] = 1'b0;
          for (int i = 0; i < 8; i++) mframe[1+i] = data_in[i];
`ifdef UART_TX_PARITY_EN
          mframe[9] = ^data_in;
`endif
          mframe[NB-1] = 1'b1;
          mpos = 1;
        end
      end else if (mpos == FL) begin
        mpos  = 0;
        mdone = 1'b1;
      end else begin
        mpos++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      if (mpos >= 1 && mpos <= FL) begin
        chk("serial_out", serial_out, mframe[(mpos-1)/N]);
        chk("tx_busy", tx_busy, 1);
      end else begin
        chk("serial_out", serial_out, 1);
        chk("tx_busy", tx_busy, 0);
      end
      chk("tx_done", tx_done, mdone);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench in cycle 1 of the new frame.
  task automatic send(input logic [7:0] b);
    tx_start = 1'b1;
    data_in  = b;
    tick();
    tx_start = 1'b0;
    data_in  = ~b;
  endtask

  task automatic capture(output logic [10:0] bits, output int cyc);
    bits = '0;
    cyc  = 1;
    for (int k = 0; k < NB; k++) begin
      while (cyc < k * N + N / 2) begin
        tick();
        cyc++;
      end
      bits[k] = serial_out;
    end
  endtask

  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (!tx_done && cyc < 400) begin
      tick();
      cyc++;
    end
    if (!tx_done) chk("tx_done_timeout", 0, 1);
  endtask

  logic [10:0] bits;
  int          cyc;
  logic [7:0]  rb;

  initial begin
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Idle after reset
    tick(100);
    chk("reset_serial", serial_out, 1);
    chk("reset_busy", tx_busy, 0);
    chk("reset_done", tx_done, 0);

    // 0x55 frame shape and done timing
    send(8'h55);
    chk("accept_fall", serial_out, 0);
    capture(bits, cyc);
    chk("bits_55", bits, BITS_55);
    wait_done(cyc, cyc);
    chk("done_cycle_55", cyc, DONE_AT);
    tick(2);

    // 0x07: parity bit set, frame length
    send(8'h07);
    capture(bits, cyc);
    chk("bits_07", bits, BITS_07);
`ifdef UART_TX_PARITY_EN
    chk("parity_07", bits[9], 1);
`endif
    wait_done(cyc, cyc);
    chk("frame_len_07", cyc - 1, FL);
    tick(3);

    // tx_start held: 0xA3 then 0x3C back to back
    tx_start = 1'b1;
    data_in  = 8'hA3;
    tick();
    data_in  = 8'h3C;
    wait_done(1, cyc);
    chk("done_cycle_a3", cyc, DONE_AT);
    chk("gap_high", serial_out, 1);
    tick();
    tx_start = 1'b0;
    data_in  = 8'h00;
    chk("b2b_start", serial_out, 0);
    chk("b2b_busy", tx_busy, 1);
    capture(bits, cyc);
    chk("bits_3c", bits, BITS_3C);
    wait_done(cyc, cyc);
    tick(2);

    // Reset during D4 of 0xFF, then 0x81
    send(8'hFF);
    tick(5 * N + 7);
    chk("pre_rst_busy", tx_busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_serial", serial_out, 1);
    chk("rst_busy", tx_busy, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    send(8'h81);
    capture(bits, cyc);
    chk("bits_81", bits, BITS_81);
    wait_done(cyc, cyc);
    tick(2);

    // Random bytes decoded from the line
    for (int i = 0; i < 48; i++) begin
      rb = 8'($urandom_range(0, 255));
      send(rb);
      capture(bits, cyc);
      chk("rand_start", bits[0], 0);
      chk("rand_byte", bits[8:1], rb);
`ifdef UART_TX_PARITY_EN
      chk("rand_parity", bits[9], ^rb);
`endif
      chk("rand_stop", bits[NB-1], 1);
      wait_done(cyc, cyc);
      chk("rand_done", cyc, DONE_AT);
      tick($urandom_range(0, 3));
    end

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
